// File: rtl/dst_pkg.sv
// Shared display-timing constants (800x600 @ 72 Hz, 50 MHz pixel clock) and
// helpers used by the sync generator and the downstream display stages.
package dst_pkg;

    localparam int H_VIS_DEF     = 800;
    localparam int H_FP_DEF      = 56;
    localparam int H_SW_DEF      = 120;
    localparam int H_BP_DEF      = 64;
    localparam int V_VIS_DEF     = 600;
    localparam int V_FP_DEF      = 37;
    localparam int V_SW_DEF      = 6;
    localparam int V_BP_DEF      = 23;
    localparam bit SYNC_POL_DEF  = 1'b1;
    localparam int BLINK_BIT_DEF = 5;

    localparam int HTOT_DEF = H_VIS_DEF + H_FP_DEF + H_SW_DEF + H_BP_DEF;
    localparam int VTOT_DEF = V_VIS_DEF + V_FP_DEF + V_SW_DEF + V_BP_DEF;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int FCNT_W = 8;

    function automatic int axis_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

endpackage

// File: rtl/dst_axis.sv
// One timing axis: wrapping position counter with terminal count, plus
// registered visible-region and sync-region decodes taken from the next count.
module dst_axis
    import dst_pkg::*;
#(
    parameter int VIS     = H_VIS_DEF,
    parameter int FP      = H_FP_DEF,
    parameter int SW      = H_SW_DEF,
    parameter int BP      = H_BP_DEF,
    parameter int W       = HCNT_W,
    parameter bit ACT_LVL = SYNC_POL_DEF
)(
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_cnt_next,
    output logic         o_tc,
    output logic         o_vis,
    output logic         o_sync
);

    localparam int TOT = axis_total(VIS, FP, SW, BP);

    localparam logic [W-1:0] L_LAST     = W'(TOT - 1);
    localparam logic [W-1:0] L_VIS      = W'(VIS);
    localparam logic [W-1:0] L_SYNC_BEG = W'(VIS + FP);
    localparam logic [W-1:0] L_SYNC_END = W'(VIS + FP + SW);

    logic [W-1:0] r_cnt;
    logic         r_vis;
    logic         r_sync;
    logic [W-1:0] w_next;
    logic         w_tc;
    logic         w_vis_next;
    logic         w_sync_next;

    always_comb begin
        w_tc        = i_en && (r_cnt == L_LAST);
        w_next      = r_cnt;
        if (i_en) begin
            w_next = w_tc ? '0 : r_cnt + W'(1);
        end
        w_vis_next  = (w_next < L_VIS);
        w_sync_next = (w_next >= L_SYNC_BEG) && (w_next < L_SYNC_END);
    end

    // Reset parks the counter on its last position so the first enabled edge wraps to 0.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt  <= L_LAST;
            r_vis  <= 1'b0;
            r_sync <= !ACT_LVL;
        end else begin
            r_cnt  <= w_next;
            r_vis  <= w_vis_next;
            r_sync <= w_sync_next ? ACT_LVL : !ACT_LVL;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = w_next;
    assign o_tc       = w_tc;
    assign o_vis      = r_vis;
    assign o_sync     = r_sync;

endmodule

// File: rtl/dst.sv
// Display sync/timing generator: horizontal and vertical axes, frame/line
// start strobes and a frame counter driving the cursor blink.
module dst
    import dst_pkg::*;
#(
    parameter int H_VIS     = H_VIS_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SW      = H_SW_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VIS     = V_VIS_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SW      = V_SW_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit SYNC_POL  = SYNC_POL_DEF,
    parameter int BLINK_BIT = BLINK_BIT_DEF
)(
    input  logic              pclk,
    input  logic              rstn,
    output logic              hs,
    output logic              vs,
    output logic              hen,
    output logic              ven,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic              frame_start,
    output logic              line_start,
    output logic              blink
);

    localparam logic [VCNT_W-1:0] L_V_VIS = VCNT_W'(V_VIS);

    logic [HCNT_W-1:0] w_h_next;
    logic [VCNT_W-1:0] w_v_next;
    logic              w_h_tc;
    logic              w_v_tc;
    logic              w_frame_next;
    logic              w_line_next;
    logic [FCNT_W-1:0] w_fcnt_next;

    logic [FCNT_W-1:0] r_fcnt;
    logic              r_frame_start;
    logic              r_line_start;
    logic              r_blink;

    dst_axis #(
        .VIS     (H_VIS),
        .FP      (H_FP),
        .SW      (H_SW),
        .BP      (H_BP),
        .W       (HCNT_W),
        .ACT_LVL (SYNC_POL)
    ) u_h_axis (
        .i_clk      (pclk),
        .i_rstn     (rstn),
        .i_en       (1'b1),
        .o_cnt      (hcnt),
        .o_cnt_next (w_h_next),
        .o_tc       (w_h_tc),
        .o_vis      (hen),
        .o_sync     (hs)
    );

    // The vertical axis only moves on the horizontal wrap, so vs can only change when hcnt becomes 0.
    dst_axis #(
        .VIS     (V_VIS),
        .FP      (V_FP),
        .SW      (V_SW),
        .BP      (V_BP),
        .W       (VCNT_W),
        .ACT_LVL (SYNC_POL)
    ) u_v_axis (
        .i_clk      (pclk),
        .i_rstn     (rstn),
        .i_en       (w_h_tc),
        .o_cnt      (vcnt),
        .o_cnt_next (w_v_next),
        .o_tc       (w_v_tc),
        .o_vis      (ven),
        .o_sync     (vs)
    );

    always_comb begin
        w_frame_next = w_h_tc && w_v_tc;
        w_line_next  = (w_h_next == '0) && (w_v_next < L_V_VIS);
        w_fcnt_next  = r_fcnt + FCNT_W'(w_frame_next);
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_fcnt        <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_blink       <= 1'b0;
        end else begin
            r_fcnt        <= w_fcnt_next;
            r_frame_start <= w_frame_next;
            r_line_start  <= w_line_next;
            r_blink       <= w_fcnt_next[BLINK_BIT];
        end
    end

    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;
    assign blink       = r_blink;

endmodule

// File: tb/tb_dst.sv
// Self-checking bench for dst using a shrunken timing so whole frames and the
// 64-frame blink period fit in a short run; expectations come from position arithmetic.
module tb_dst;

    localparam int H_VIS = 8;
    localparam int H_FP  = 2;
    localparam int H_SW  = 3;
    localparam int H_BP  = 2;
    localparam int V_VIS = 6;
    localparam int V_FP  = 2;
    localparam int V_SW  = 2;
    localparam int V_BP  = 1;
    localparam bit POL   = 1'b0;
    localparam int BLINK_BIT = 5;
    localparam int HTOT  = H_VIS + H_FP + H_SW + H_BP;
    localparam int VTOT  = V_VIS + V_FP + V_SW + V_BP;
    localparam int FRAME = HTOT * VTOT;

    logic        pclk = 1'b0;
    logic        rstn = 1'b0;
    logic        hs, vs, hen, ven, frameStart, lineStart, blink;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic [27:0] dutVec;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    assign dutVec = {hs, vs, hen, ven, hcnt, vcnt, frameStart, lineStart, blink};

    dst #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP),
        .SYNC_POL(POL), .BLINK_BIT(BLINK_BIT)
    ) uDut (
        .pclk(pclk), .rstn(rstn), .hs(hs), .vs(vs), .hen(hen), .ven(ven),
        .hcnt(hcnt), .vcnt(vcnt), .frame_start(frameStart),
        .line_start(lineStart), .blink(blink)
    );

    always #5 pclk = ~pclk;

    function automatic logic [27:0] resetVec();
        return {!POL, !POL, 1'b0, 1'b0, 11'(HTOT - 1), 10'(VTOT - 1), 1'b0, 1'b0, 1'b0};
    endfunction

    // Expected outputs after t edges since reset release, from raster position alone.
    function automatic logic [27:0] model(input int t);
        int p, hm, vm, fr;
        logic hsE, vsE, blE;
        p   = t - 1;
        hm  = p % HTOT;
        vm  = (p / HTOT) % VTOT;
        fr  = (p / FRAME + 1) % 256;
        hsE = (hm >= H_VIS + H_FP && hm < H_VIS + H_FP + H_SW) ? POL : !POL;
        vsE = (vm >= V_VIS + V_FP && vm < V_VIS + V_FP + V_SW) ? POL : !POL;
        blE = ((fr / (1 << BLINK_BIT)) % 2) == 1;
        return {hsE, vsE, hm < H_VIS, vm < V_VIS, 11'(hm), 10'(vm),
                hm == 0 && vm == 0, hm == 0 && vm < V_VIS, blE};
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if (dutVec !== resetVec()) begin
            errors++;
            $display("[TB] FAIL reset_hold got=%h exp=%h", dutVec, resetVec());
        end
        @(negedge pclk);
        rstn = 1'b1;
        @(posedge pclk);
        #1;
        cyc = 1;
        checks++;
        if ({hcnt, vcnt, hen, ven, frameStart, lineStart, blink} !== {11'd0, 10'd0, 5'b11110}) begin
            errors++;
            $display("[TB] FAIL first_edge got=%h exp=%h", dutVec, model(cyc));
        end
        checks++;
        if (dutVec !== model(cyc)) begin
            errors++;
            $display("[TB] FAIL first_edge_vec got=%h exp=%h", dutVec, model(cyc));
        end
    endtask

    task automatic test_line();
        int henCnt = 0;
        int hsCnt = 0;
        int hsFirst = -1;
        for (int i = 0; i < HTOT; i++) begin
            if (i > 0) begin
                @(posedge pclk);
                #1;
                cyc++;
                checks++;
                if (dutVec !== model(cyc)) begin
                    errors++;
                    $display("[TB] FAIL line_vec cyc=%0d got=%h exp=%h", cyc, dutVec, model(cyc));
                end
            end
            if (hen) henCnt++;
            if (hs === POL) begin
                hsCnt++;
                if (hsFirst < 0) hsFirst = int'(hcnt);
            end
        end
        checks++;
        if (henCnt != H_VIS) begin
            errors++;
            $display("[TB] FAIL hen_width got=%0d exp=%0d", henCnt, H_VIS);
        end
        checks++;
        if (hsCnt != H_SW || hsFirst != H_VIS + H_FP) begin
            errors++;
            $display("[TB] FAIL hs_window got=%0d@%0d exp=%0d@%0d", hsCnt, hsFirst, H_SW, H_VIS + H_FP);
        end
        @(posedge pclk);
        #1;
        cyc++;
        checks++;
        if (lineStart !== 1'b1 || hcnt !== 11'd0 || vcnt !== 10'd1) begin
            errors++;
            $display("[TB] FAIL line_period got=%b,%0d,%0d exp=1,0,1", lineStart, hcnt, vcnt);
        end
    endtask

    task automatic test_frame();
        int guard = 0;
        int lines = 0;
        int pix = 0;
        int vsLines = 0;
        int vsFirst = -1;
        int venLow = 0;
        int px = 0;
        int py = 0;
        logic prevVs;
        while (frameStart !== 1'b1 && guard < FRAME + 2) begin
            @(posedge pclk);
            #1;
            cyc++;
            guard++;
            checks++;
            if (dutVec !== model(cyc)) begin
                errors++;
                $display("[TB] FAIL frame_seek cyc=%0d got=%h exp=%h", cyc, dutVec, model(cyc));
            end
        end
        checks++;
        if (frameStart !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_timeout got=%b exp=1", frameStart);
        end
        prevVs = vs;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) begin
                @(posedge pclk);
                #1;
                cyc++;
                checks++;
                if (dutVec !== model(cyc)) begin
                    errors++;
                    $display("[TB] FAIL frame_vec cyc=%0d got=%h exp=%h", cyc, dutVec, model(cyc));
                end
                if (vs !== prevVs) begin
                    checks++;
                    if (hcnt !== 11'd0) begin
                        errors++;
                        $display("[TB] FAIL vs_edge_pos got=%0d exp=0", hcnt);
                    end
                end
                if (frameStart) begin
                    errors++;
                    $display("[TB] FAIL frame_early cyc=%0d got=1 exp=0", cyc);
                end
            end
            prevVs = vs;
            if (lineStart) lines++;
            if (hcnt == 11'd0 && vs === POL) begin
                vsLines++;
                if (vsFirst < 0) vsFirst = int'(vcnt);
            end
            if (hcnt == 11'd0 && !ven) venLow++;
            if (hen && ven) begin
                pix++;
                checks++;
                if (int'(hcnt) != px || int'(vcnt) != py) begin
                    errors++;
                    $display("[TB] FAIL pixel_pos got=%0d,%0d exp=%0d,%0d", hcnt, vcnt, px, py);
                end
                if (px == H_VIS - 1) begin
                    px = 0;
                    py = (py == V_VIS - 1) ? 0 : py + 1;
                end else begin
                    px++;
                end
            end
        end
        checks++;
        if (lines != V_VIS) begin
            errors++;
            $display("[TB] FAIL line_starts got=%0d exp=%0d", lines, V_VIS);
        end
        checks++;
        if (pix != H_VIS * V_VIS || px != 0 || py != 0) begin
            errors++;
            $display("[TB] FAIL pixel_count got=%0d@(%0d,%0d) exp=%0d@(0,0)", pix, px, py, H_VIS * V_VIS);
        end
        checks++;
        if (vsLines != V_SW || vsFirst != V_VIS + V_FP) begin
            errors++;
            $display("[TB] FAIL vs_window got=%0d@%0d exp=%0d@%0d", vsLines, vsFirst, V_SW, V_VIS + V_FP);
        end
        checks++;
        if (venLow != VTOT - V_VIS) begin
            errors++;
            $display("[TB] FAIL ven_low_lines got=%0d exp=%0d", venLow, VTOT - V_VIS);
        end
        @(posedge pclk);
        #1;
        cyc++;
        checks++;
        if (frameStart !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_period got=%b exp=1", frameStart);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++) begin
            int guard = 0;
            int runLen;
            if (k == 0) begin
                while (!(hcnt == 11'd4 && vcnt == 10'd3) && guard < 2 * FRAME) begin
                    @(posedge pclk);
                    #1;
                    cyc++;
                    guard++;
                    checks++;
                    if (dutVec !== model(cyc)) begin
                        errors++;
                        $display("[TB] FAIL pre_reset_vec cyc=%0d got=%h exp=%h", cyc, dutVec, model(cyc));
                    end
                end
                checks++;
                if (guard >= 2 * FRAME) begin
                    errors++;
                    $display("[TB] FAIL seek_timeout got=%0d,%0d exp=4,3", hcnt, vcnt);
                end
            end else begin
                runLen = $urandom_range(1, 2 * FRAME);
                repeat (runLen) begin
                    @(posedge pclk);
                    #1;
                    cyc++;
                    checks++;
                    if (dutVec !== model(cyc)) begin
                        errors++;
                        $display("[TB] FAIL pre_reset_vec cyc=%0d got=%h exp=%h", cyc, dutVec, model(cyc));
                    end
                end
            end
            #($urandom_range(1, 3));
            rstn = 1'b0;
            #1;
            checks++;
            if (dutVec !== resetVec()) begin
                errors++;
                $display("[TB] FAIL async_reset got=%h exp=%h", dutVec, resetVec());
            end
            repeat ($urandom_range(1, 4)) @(posedge pclk);
            #1;
            checks++;
            if (dutVec !== resetVec()) begin
                errors++;
                $display("[TB] FAIL reset_held got=%h exp=%h", dutVec, resetVec());
            end
            @(negedge pclk);
            rstn = 1'b1;
            cyc = 0;
            repeat (HTOT + 2) begin
                @(posedge pclk);
                #1;
                cyc++;
                checks++;
                if (dutVec !== model(cyc)) begin
                    errors++;
                    $display("[TB] FAIL restart_vec cyc=%0d got=%h exp=%h", cyc, dutVec, model(cyc));
                end
            end
        end
    endtask

    task automatic test_blink();
        int riseCyc = -1;
        int fallCyc = -1;
        logic prevBlink;
        @(posedge pclk);
        #2;
        rstn = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        rstn = 1'b1;
        cyc = 0;
        prevBlink = 1'b0;
        repeat (64 * FRAME + HTOT) begin
            @(posedge pclk);
            #1;
            cyc++;
            checks++;
            if (dutVec !== model(cyc)) begin
                errors++;
                $display("[TB] FAIL blink_vec cyc=%0d got=%h exp=%h", cyc, dutVec, model(cyc));
            end
            if (blink === 1'b1 && prevBlink === 1'b0 && riseCyc < 0) riseCyc = cyc;
            if (blink === 1'b0 && prevBlink === 1'b1 && fallCyc < 0) fallCyc = cyc;
            prevBlink = blink;
        end
        checks++;
        if (riseCyc != 31 * FRAME + 1) begin
            errors++;
            $display("[TB] FAIL blink_rise got=%0d exp=%0d", riseCyc, 31 * FRAME + 1);
        end
        checks++;
        if (fallCyc != 63 * FRAME + 1) begin
            errors++;
            $display("[TB] FAIL blink_fall got=%0d exp=%0d", fallCyc, 63 * FRAME + 1);
        end
    endtask

    initial begin
        $display("[TB] dst bench start, HTOT=%0d VTOT=%0d", HTOT, VTOT);
        test_reset();
        test_line();
        test_frame();
        test_async_reset();
        test_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dst.md
DST -- requirements
Module: dst

Interface
REQ-001 Param H_VIS, default 800, visible pixels per line.
REQ-002 Param H_FP, default 56, horizontal front porch in pclk cycles.
REQ-003 Param H_SW, default 120, hsync width in pclk cycles.
REQ-004 Param H_BP, default 64, horizontal back porch in pclk cycles.
REQ-005 Param V_VIS, default 600, visible lines per frame.
REQ-006 Param V_FP, default 37, vertical front porch in lines.
REQ-007 Param V_SW, default 6, vsync width in lines.
REQ-008 Param V_BP, default 23, vertical back porch in lines.
REQ-009 Param SYNC_POL, default 1, sync active level (1 = active-high).
REQ-010 Param BLINK_BIT, default 5, frame-counter bit driving blink.
REQ-011 pclk  in  1  pixel clock (50 MHz); single clock domain, all logic on rising edge.
REQ-012 rstn  in  1  reset, asynchronous assert, active-low.
REQ-013 hs  out  1  horizontal sync at SYNC_POL level.
REQ-014 vs  out  1  vertical sync at SYNC_POL level.
REQ-015 hen  out  1  high while the horizontal position is inside the visible region.
REQ-016 ven  out  1  high while the vertical position is inside the visible region.
REQ-017 hcnt  out  11  horizontal position, 0..HTOT-1, where HTOT = H_VIS+H_FP+H_SW+H_BP = 1040.
REQ-018 vcnt  out  10  vertical position, 0..VTOT-1, where VTOT = 666.
REQ-019 frame_start  out  1  one-cycle pulse when hcnt=0 and vcnt=0.
REQ-020 line_start  out  1  one-cycle pulse when hcnt=0 and vcnt<V_VIS.
REQ-021 blink  out  1  fcnt[BLINK_BIT]; toggles every 32 frames by default (cursor blink).

Function
REQ-022 hcnt SHALL increment every pclk and wrap from HTOT-1 to 0.
REQ-023 vcnt SHALL increment only on the hcnt wrap, and SHALL wrap from VTOT-1 to 0 on the simultaneous H and V wrap.
REQ-024 All outputs SHALL be registers computed from next-state counter values, so every output is coincident with hcnt/vcnt in the same cycle and glitch-free.
REQ-025 hen SHALL be high iff hcnt < H_VIS.
REQ-026 ven SHALL be high iff vcnt < V_VIS.
REQ-027 hs SHALL be active iff H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SW, i.e. 856..975.
REQ-028 vs SHALL be active iff V_VIS+V_FP <= vcnt < V_VIS+V_FP+V_SW, i.e. 637..642.
REQ-029 vs SHALL change only in cycles where hcnt=0.
REQ-030 hen&&ven SHALL be asserted exactly H_VIS*V_VIS = 480000 cycles per frame, so a downstream pixel counter running on hen&&ven wraps at (799,599) exactly once per frame.
REQ-031 fcnt (8 bit, internal) SHALL increment on each frame_start and wrap 255->0.

Reset
REQ-032 While rstn=0: hcnt=HTOT-1, vcnt=VTOT-1, hs=vs=!SYNC_POL, hen=ven=0, frame_start=line_start=0, fcnt=0, blink=0.
REQ-033 On the first pclk edge after rstn deasserts: hcnt=0, vcnt=0, hen=ven=1, frame_start=1, line_start=1.
REQ-034 fcnt SHALL increment to 1 on that same first frame_start.
REQ-035 Reset asserted mid-frame SHALL return all outputs to their REQ-032 values immediately, without waiting for a pclk edge.

Structure
REQ-036 The shared package SHALL hold the timing constants (H_/V_ visible, porch and sync values, HTOT, VTOT) and SYNC_POL, for use by this block and the display stages.
REQ-037 One sub-module, dst_axis (wrapping counter with terminal-count output and two region decodes), SHALL be instantiated twice: horizontal, and vertical enabled by the horizontal terminal count.

Verification
REQ-038 Release rstn -> next edge: hcnt=0, vcnt=0, hen=1, ven=1, frame_start=1; frame_start recurs exactly every 692640 cycles.
REQ-039 Run one line -> hen high for 800 cycles; hs active for 120 cycles starting at hcnt=856; line period 1040 cycles.
REQ-040 Run one frame -> ven low from vcnt=600 to 665; vs active for 6 lines starting at vcnt=637 with the edge at hcnt=0; 600 line_start pulses per frame.
REQ-041 Count cycles with hen&&ven over one frame -> exactly 480000; a reference pixel counter sits at (0,0) after each frame.
REQ-042 Assert rstn=0 asynchronously at hcnt=400, vcnt=300 -> outputs take their reset values before the next edge; on release the sequence restarts per REQ-033.
REQ-043 Run 64 frames -> blink rises after frame 32 and falls after frame 64 (BLINK_BIT=5).
